uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
8N1 UART receiver, the counterpart of the existing UART_TX transmitter on the same serial line. It synchronises the asynchronous RX input into the clock domain and validates the start bit at mid-bit. It then samples 8 data bits LSB-first plus the stop bit, and presents each received byte with a one-cycle valid strobe to the command parser.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 8..65535
SYNC_STAGES, 2, number of flip-flops in the RX input synchroniser; legal range 2..4

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous active-low reset, sampled on the rising edge of clk
RX  input  1  asynchronous serial input; idles high
RX_data  output  8  last received byte; holds its value until the next valid frame
RX_valid  output  1  one-cycle strobe; RX_data is valid in the same cycle
RX_frame_err  output  1  one-cycle strobe when the stop bit is sampled low
q_busy  output  1  high from start-bit detection until the FSM returns to IDLE

Behaviour:
- Reset (reset==0 at a clk edge): FSM=IDLE, bit counter=0, clock counter=0, synchroniser preset to 1, RX_data=8'h00, RX_valid=0, RX_frame_err=0, q_busy=0.
- Reset wins over every other event; reset mid-frame discards the partial byte and produces no strobe.
- Every cycle, RX passes through the SYNC_STAGES FF chain; the FSM uses only the synchronised bit rx_s.
- IDLE: rx_s==0 -> START, clock counter=0, q_busy=1 on the next cycle.
- START: at clock counter==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - rx_s==1 -> glitch: go to IDLE, q_busy=0, no strobe.
  - rx_s==0 -> DATA, clock counter=0, bit counter=0.
- DATA: at clock counter==CLKS_PER_BIT-1, sample rx_s into shift register bit[bit counter] (LSB first) and reset the clock counter.
  - After bit counter==7 -> STOP (or PARITY when enabled).
- STOP: at clock counter==CLKS_PER_BIT-1, sample rx_s.
  - 1 -> next cycle: RX_data<=shift register, RX_valid=1 for exactly one cycle; go to IDLE.
  - 0 -> next cycle: RX_frame_err=1 for one cycle; RX_data unchanged; go to BREAK.
- BREAK: wait until rx_s==1, then IDLE. Prevents a held-low line (break) from retriggering reception.
- q_busy deasserts on the cycle the FSM enters IDLE.
- A new start edge is accepted in the first IDLE cycle, so back-to-back frames with zero idle time work.
- RX_valid and RX_frame_err are never high in the same cycle.
- The clock counter width is clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.
- Latency: RX_valid rises 1 + SYNC_STAGES + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles (within ±1) after the RX falling edge of the start bit.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit at the same CLKS_PER_BIT spacing. Adds output port RX_parity_err (1 bit), reset value 0.
  - Parity mismatch (XOR of data and parity bit != 0): RX_parity_err pulses for one cycle in place of RX_valid; RX_data is not updated.
  - Framing error takes precedence over parity error: only RX_frame_err pulses.
- Undefined: no PARITY state and no RX_parity_err port; the 8N1 behaviour above applies.

Test Plan:
- Drive 0xA5 at 115200 (8680 ns/bit) after reset release -> exactly one RX_valid with RX_data=8'hA5, ~9.5 bit-times after the start edge; RX_frame_err stays 0.
- Back-to-back 0x3C then 0xC3 with zero idle between the stop bit and the next start bit -> two RX_valid strobes with data 8'h3C then 8'hC3, separated by 10*434 ±1 cycles.
- 100-cycle low pulse on an idle line -> q_busy high then low within CLKS_PER_BIT/2 + 4 cycles; no RX_valid and no RX_frame_err.
- Frame 0x55 with the stop bit driven low, then line held low for 3 bit-times, then released -> one RX_frame_err, RX_data keeps its previous value, no further strobes until a new start edge.
- reset=0 during bit 4 of 0xFF, reset=1 after 40 ns, then send 0x81 -> no strobe for the aborted frame; RX_valid with 8'h81.
- With UART_RX_PARITY_EN defined: 0x07 sent with parity bit 0 -> RX_parity_err pulse, RX_data unchanged; same byte with parity bit 1 -> RX_valid with 8'h07.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver for the line driven by UART_TX.
// RX passes through a SYNC_STAGES-deep synchroniser. The start bit is
// re-checked at mid-bit, and the data and stop bits are sampled one bit
// period apart from that point. Each good byte is presented with a
// one-cycle RX_valid strobe.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1. It adds
// a PARITY state and the RX_parity_err output.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] RX_data,
    output logic       RX_valid,
    output logic       RX_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       RX_parity_err,
`endif
    output logic       q_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t ST_AFTER_DATA = ST_PARITY;

    // Even parity: the data byte and its parity bit together must hold an even number of ones
    function automatic logic even_parity_err(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`else
    localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       clk_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_r;
`endif

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Synchronise the asynchronous RX line. Reset presets the chain to the idle-high level
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], RX};
        end
    end

    // Receive FSM: bit timing, data capture and registered result strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            clk_cnt_r     <= '0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            RX_data       <= 8'h00;
            RX_valid      <= 1'b0;
            RX_frame_err  <= 1'b0;
            q_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r     <= 1'b0;
            RX_parity_err <= 1'b0;
`endif
        end else begin
            RX_valid     <= 1'b0;
            RX_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            RX_parity_err <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_r   <= ST_START;
                        clk_cnt_r <= '0;
                        q_busy    <= 1'b1;
                    end else begin
                        q_busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (clk_cnt_r == HALF_LAST) begin
                        clk_cnt_r <= '0;
                        if (rx_s) begin
                            // The line went high again before mid-bit, so treat it as a glitch.
                            state_r <= ST_IDLE;
                            q_busy  <= 1'b0;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_r == BIT_LAST) begin
                        clk_cnt_r          <= '0;
                        shift_r[bit_cnt_r] <= rx_s;
                        if (bit_cnt_r == 3'd7) begin
                            state_r   <= ST_AFTER_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt_r == BIT_LAST) begin
                        clk_cnt_r <= '0;
                        par_err_r <= even_parity_err(shift_r, rx_s);
                        state_r   <= ST_STOP;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt_r == BIT_LAST) begin
                        clk_cnt_r <= '0;
                        if (rx_s) begin
                            state_r <= ST_IDLE;
                            q_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_err_r) begin
                                RX_parity_err <= 1'b1;
                            end else begin
                                RX_data  <= shift_r;
                                RX_valid <= 1'b1;
                            end
`else
                            RX_data  <= shift_r;
                            RX_valid <= 1'b1;
`endif
                        end else begin
                            // A framing error overrides any parity result. Wait for the line to recover.
                            RX_frame_err <= 1'b1;
                            state_r      <= ST_BREAK;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                        q_busy  <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_cnt_r <= '0;
                    q_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: serial-line stimulus for uart_rx_frame. Expected bytes,
// strobe counts and latencies come from the frame rules (bit times, LSB first,
// stop/parity outcome) and are compared against strobes captured by a monitor.
module tb_uart_rx_frame;

    localparam int CLKS = 434;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // From the start edge to the strobe: sync + detect + half bit + data (+parity) + stop.
    localparam int LAT = 1 + SYNC + CLKS / 2 + (FRAME_BITS - 1) * CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RX = 1'b1;
    logic [7:0] RX_data;
    logic       RX_valid;
    logic       RX_frame_err;
    logic       q_busy;
`ifdef UART_RX_PARITY_EN
    logic       RX_parity_err;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [7:0] last_good = 8'h00;

    logic [7:0] vdata_q[$];
    int         vcyc_q[$];
    int         fcyc_q[$];
    int         pcnt = 0;
    int         both_cnt = 0;

    uart_rx_frame #(.CLKS_PER_BIT(CLKS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .reset(reset),
        .RX(RX),
        .RX_data(RX_data),
        .RX_valid(RX_valid),
        .RX_frame_err(RX_frame_err),
`ifdef UART_RX_PARITY_EN
        .RX_parity_err(RX_parity_err),
`endif
        .q_busy(q_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (RX_valid === 1'b1) begin
            vdata_q.push_back(RX_data);
            vcyc_q.push_back(cyc);
        end
        if (RX_frame_err === 1'b1) fcyc_q.push_back(cyc);
`ifdef UART_RX_PARITY_EN
        if (RX_parity_err === 1'b1) pcnt++;
`endif
        if (RX_valid === 1'b1 && RX_frame_err === 1'b1) both_cnt++;
    end

    // Drive one frame: start, 8 data LSB first, optional parity, stop; starts and ends on a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        RX = 1'b0;
        start_cyc = cyc;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        RX = par_bit;
        repeat (CLKS) @(negedge clk);
`endif
        RX = stop_bit;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (RX_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", RX_data); end
        n_checks++; if (RX_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", RX_valid); end
        n_checks++; if (RX_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", RX_frame_err); end
        n_checks++; if (q_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", q_busy); end
        reset = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_good_frame(input logic [7:0] d, input string tag);
        int vb = vdata_q.size();
        int fb = fcyc_q.size();
        int lat;
        send_frame(d, 1'b1, ^d);
        repeat (10) @(negedge clk);
        n_checks++;
        if (vdata_q.size() - vb !== 1) begin
            n_fail++; $display("FAIL %s_count got=%0d exp=1", tag, vdata_q.size() - vb);
        end else begin
            n_checks++;
            if (vdata_q[vb] !== d) begin n_fail++; $display("FAIL %s_data got=%h exp=%h", tag, vdata_q[vb], d); end
            lat = vcyc_q[vb] - start_cyc;
            n_checks++;
            if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, LAT); end
        end
        n_checks++; if (fcyc_q.size() !== fb) begin n_fail++; $display("FAIL %s_ferr got=%0d exp=0", tag, fcyc_q.size() - fb); end
        last_good = d;
    endtask

    task automatic test_back_to_back();
        int vb = vdata_q.size();
        int sep;
        send_frame(8'h3C, 1'b1, ^8'h3C);
        send_frame(8'hC3, 1'b1, ^8'hC3);
        repeat (10) @(negedge clk);
        n_checks++;
        if (vdata_q.size() - vb !== 2) begin
            n_fail++; $display("FAIL b2b_count got=%0d exp=2", vdata_q.size() - vb);
        end else begin
            n_checks++; if (vdata_q[vb] !== 8'h3C) begin n_fail++; $display("FAIL b2b_first got=%h exp=3c", vdata_q[vb]); end
            n_checks++; if (vdata_q[vb+1] !== 8'hC3) begin n_fail++; $display("FAIL b2b_second got=%h exp=c3", vdata_q[vb+1]); end
            sep = vcyc_q[vb+1] - vcyc_q[vb];
            n_checks++;
            if (sep < FRAME_BITS * CLKS - 1 || sep > FRAME_BITS * CLKS + 1) begin
                n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", sep, FRAME_BITS * CLKS);
            end
        end
        last_good = 8'hC3;
    endtask

    task automatic test_glitch();
        int vb = vdata_q.size();
        int fb = fcyc_q.size();
        int t0 = cyc;
        int rise = -1;
        int fall = -1;
        RX = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 100) RX = 1'b1;
            @(negedge clk);
            if (q_busy === 1'b1 && rise < 0) rise = cyc - t0;
            if (q_busy === 1'b0 && rise >= 0 && fall < 0) fall = cyc - t0;
        end
        n_checks++; if (rise < 0) begin n_fail++; $display("FAIL glitch_busy_rise got=none exp=high"); end
        n_checks++;
        if (fall < 0 || fall > CLKS / 2 + 4) begin
            n_fail++; $display("FAIL glitch_busy_fall got=%0d exp<=%0d", fall, CLKS / 2 + 4);
        end
        n_checks++; if (vdata_q.size() !== vb) begin n_fail++; $display("FAIL glitch_valid got=%0d exp=0", vdata_q.size() - vb); end
        n_checks++; if (fcyc_q.size() !== fb) begin n_fail++; $display("FAIL glitch_ferr got=%0d exp=0", fcyc_q.size() - fb); end
    endtask

    task automatic test_framing();
        int vb = vdata_q.size();
        int fb = fcyc_q.size();
        send_frame(8'h55, 1'b0, ^8'h55);
        RX = 1'b0;
        repeat (3 * CLKS) @(negedge clk);
        RX = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        n_checks++; if (fcyc_q.size() - fb !== 1) begin n_fail++; $display("FAIL frame_err_count got=%0d exp=1", fcyc_q.size() - fb); end
        n_checks++; if (vdata_q.size() !== vb) begin n_fail++; $display("FAIL frame_valid got=%0d exp=0", vdata_q.size() - vb); end
        n_checks++; if (RX_data !== last_good) begin n_fail++; $display("FAIL frame_data_held got=%h exp=%h", RX_data, last_good); end
        n_checks++; if (q_busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_idle got=%b exp=0", q_busy); end
    endtask

    task automatic test_reset_midframe();
        int vb = vdata_q.size();
        int fb = fcyc_q.size();
        logic [7:0] d = 8'hFF;
        RX = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = d[i];
            repeat (CLKS) @(negedge clk);
        end
        RX = d[4];
        repeat (200) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (CLKS - 202) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            RX = d[i];
            repeat (CLKS) @(negedge clk);
        end
        RX = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        last_good = 8'h00;
        n_checks++; if (vdata_q.size() !== vb) begin n_fail++; $display("FAIL abort_valid got=%0d exp=0", vdata_q.size() - vb); end
        n_checks++; if (fcyc_q.size() !== fb) begin n_fail++; $display("FAIL abort_ferr got=%0d exp=0", fcyc_q.size() - fb); end
        n_checks++; if (RX_data !== last_good) begin n_fail++; $display("FAIL abort_data got=%h exp=%h", RX_data, last_good); end
        n_checks++; if (q_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", q_busy); end
        test_good_frame(8'h81, "after_abort");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            test_good_frame(d, "random");
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int vb = vdata_q.size();
        int pb = pcnt;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        n_checks++; if (pcnt - pb !== 1) begin n_fail++; $display("FAIL parity_err_count got=%0d exp=1", pcnt - pb); end
        n_checks++; if (vdata_q.size() !== vb) begin n_fail++; $display("FAIL parity_valid got=%0d exp=0", vdata_q.size() - vb); end
        n_checks++; if (RX_data !== last_good) begin n_fail++; $display("FAIL parity_data_held got=%h exp=%h", RX_data, last_good); end
        test_good_frame(8'h07, "parity_ok");
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame(8'hA5, "a5");
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_ferr_together got=%0d exp=0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
